// File: rtl/parity_scheduler.sv
// parity_scheduler
// Shares one 4-input XOR parity stage among four requesters. A round-robin
// arbiter picks a requester, its W-bit word is shifted through the XOR stage
// one nibble per cycle, and the accumulated parity is offered on a
// valid/ready result port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   per-requester request, bit i = requester i
//   data       requester i's word on data[i*W +: W]
//   gnt[3:0]   one-hot, one-cycle acceptance pulse
//   busy       high while a job is running or its result is pending
//   res_valid  parity result available
//   res_ready  consumer accepts the result
//   res_id     requester index owning the result
//   res_parity XOR of all W bits of the granted word
module parity_scheduler #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data,
  output logic [3:0]     gnt,
  output logic           busy,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [1:0]     res_id,
  output logic           res_parity
);

  localparam int NIB = W / 4;
  localparam int CW  = $clog2(NIB + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [W-1:0]    sr_q, sr_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      res_id_q, res_id_d;
  logic            res_parity_q, res_parity_d;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      gnt_q, gnt_d;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      cand;

  logic            x_ab;
  logic            x_abc;
  logic            nib_par;

  // The shared XOR cascade: a^b, then ^c, then ^d on the low nibble.
  assign x_ab    = sr_q[0] ^ sr_q[1];
  assign x_abc   = x_ab ^ sr_q[2];
  assign nib_par = x_abc ^ sr_q[3];

  // Round-robin search starting just after the last winner. The candidate
  // offset wraps through the 2-bit add, so offset 4 lands back on ptr itself
  // and the previous winner gets the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic: capture in IDLE, one nibble per cycle in RUN, hold the
  // result in DONE until the consumer takes it.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sr_d         = sr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_id_d     = res_id_q;
    res_parity_d = res_parity_q;
    res_valid_d  = res_valid_q;
    gnt_d        = 4'b0000;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          sr_d     = data[int'(win_idx) * W +: W];
          acc_d    = 1'b0;
          cnt_d    = '0;
          ptr_d    = win_idx;
          res_id_d = win_idx;
          gnt_d    = 4'b0001 << win_idx;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q ^ nib_par;
        sr_d  = sr_q >> 4;
        cnt_d = cnt_q + CW'(1);
        // Last nibble: publish the parity including this nibble directly,
        // since acc_q does not yet contain it.
        if (cnt_q == CW'(NIB - 1)) begin
          res_parity_d = acc_q ^ nib_par;
          res_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; ptr resets to 3 so
  // requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd3;
      sr_q         <= '0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      res_id_q     <= 2'd0;
      res_parity_q <= 1'b0;
      res_valid_q  <= 1'b0;
      gnt_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_id_q     <= res_id_d;
      res_parity_q <= res_parity_d;
      res_valid_q  <= res_valid_d;
      gnt_q        <= gnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_parity = res_parity_q;

endmodule

// File: tb/tb_parity_scheduler.sv
// tb_parity_scheduler
// Self-checking bench for parity_scheduler (W=16). Expected results are
// pushed to a scoreboard queue when requests are driven and popped when the
// DUT presents a result. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_parity_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic        res_parity;

  typedef struct packed {
    logic [1:0] id;
    logic       par;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_ptr;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_cnt = 0;

  parity_scheduler #(.W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data_in),
    .gnt        (gnt),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_parity (res_parity)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure grant spacing.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference arbiter: walk from the farthest candidate to the nearest so the
  // nearest set request after p is the one left standing.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] k;
    rr_pick = p;
    for (int i = 4; i >= 1; i--) begin
      k = p + 2'(i);
      if (r[k]) rr_pick = k;
    end
  endfunction

  // Drive a request pattern and record the job the reference arbiter expects.
  task automatic submit(input logic [3:0] r);
    logic [1:0]  w;
    logic [15:0] word;
    req  = r;
    w    = rr_pick(m_ptr, r);
    word = data_in[int'(w) * 16 +: 16];
    sb.push_back('{id: w, par: ^word});
    m_ptr = w;
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic wait_gnt(output logic [3:0] g, output int waited);
    waited = 0;
    @(negedge clk);
    waited++;
    while (gnt == 4'b0000 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    g = gnt;
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (res_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    data_in   = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    m_ptr = 2'd3;
    sb.delete();
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", res_valid); end
    n_cmp++; if (res_id !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_id: got %0d want 0", res_id); end
    n_cmp++; if (res_parity !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_parity: got %b want 0", res_parity); end
  endtask

  task automatic test_single_job();
    logic [3:0] g;
    int         waited;
    exp_t       e;
    rst_n   = 1'b1;
    data_in = 64'h0000_0000_0000_0001;
    submit(4'b0001);
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("[TB] FAIL single_gnt: got %b want 0001", g); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("[TB] FAIL single_gnt_pulse: got %b want 0000", gnt); end
    wait_valid(waited);
    n_cmp++; if (waited != 3) begin n_bad++; $display("[TB] FAIL single_latency: got %0d want 3 cycles after gnt+1", waited); end
    e = pop_exp();
    n_cmp++; if ({res_id, res_parity} !== {e.id, e.par}) begin n_bad++; $display("[TB] FAIL single_result: got id=%0d par=%b want id=%0d par=%b", res_id, res_parity, e.id, e.par); end
    @(negedge clk);
    n_cmp++; if ({res_valid, busy} !== 2'b00) begin n_bad++; $display("[TB] FAIL single_release: got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_parity_values();
    logic [15:0] words[3];
    logic [3:0]  g;
    int          waited;
    exp_t        e;
    words[0] = 16'hFFFF;
    words[1] = 16'h8001;
    words[2] = 16'h7000;
    for (int k = 0; k < 3; k++) begin
      data_in = '0;
      data_in[47:32] = words[k];
      submit(4'b0100);
      wait_gnt(g, waited);
      n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("[TB] FAIL parity_gnt%0d: got %b want 0100", k, g); end
      req = 4'b0000;
      wait_valid(waited);
      e = pop_exp();
      n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL parity_result%0d: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", k, res_valid, res_id, res_parity, e.id, e.par); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order[5];
    logic [3:0] g;
    int         waited;
    int         prev;
    exp_t       e;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 2'd3;
    sb.delete();
    data_in   = {16'hFFFE, 16'hA5A4, 16'h0F0F, 16'h1234};
    res_ready = 1'b1;
    prev      = 0;
    for (int k = 0; k < 5; k++) begin
      submit(4'b1111);
      wait_gnt(g, waited);
      n_cmp++; if (g !== (4'b0001 << order[k])) begin n_bad++; $display("[TB] FAIL rr_gnt%0d: got %b want %b", k, g, 4'b0001 << order[k]); end
      if (k > 0) begin
        n_cmp++; if (cyc_cnt - prev != 6) begin n_bad++; $display("[TB] FAIL rr_period%0d: got %0d want 6", k, cyc_cnt - prev); end
      end
      prev = cyc_cnt;
      if (k == 4) req = 4'b0000;
      wait_valid(waited);
      e = pop_exp();
      n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL rr_result%0d: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", k, res_valid, res_id, res_parity, e.id, e.par); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [3:0] g;
    int         waited;
    exp_t       e;
    res_ready = 1'b0;
    data_in   = {16'h0000, 16'h0003, 16'h0007, 16'h0000};
    submit(4'b0010);
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("[TB] FAIL bp_gnt: got %b want 0010", g); end
    req = 4'b0000;
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL bp_result: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    submit(4'b0100);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++; if ({res_valid, res_id, res_parity, gnt} !== {1'b1, e.id, e.par, 4'b0000}) begin n_bad++; $display("[TB] FAIL bp_hold%0d: got v=%b id=%0d par=%b gnt=%b want v=1 id=%0d par=%b gnt=0000", c, res_valid, res_id, res_parity, gnt, e.id, e.par); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({res_valid, gnt} !== 5'b0) begin n_bad++; $display("[TB] FAIL bp_transfer: got v=%b gnt=%b want v=0 gnt=0000", res_valid, gnt); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("[TB] FAIL bp_next_gnt: got %b want 0100", gnt); end
    req = 4'b0000;
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL bp_result2: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] g;
    int         waited;
    int         hits;
    exp_t       e;
    data_in = {16'h0000, 16'h0000, 16'h0001, 16'h0000};
    submit(4'b0010);
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("[TB] FAIL mid_gnt: got %b want 0010", g); end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({gnt, busy, res_valid, res_id, res_parity} !== 9'b0) begin n_bad++; $display("[TB] FAIL mid_reset: got gnt=%b busy=%b v=%b id=%0d par=%b want all 0", gnt, busy, res_valid, res_id, res_parity); end
    void'(sb.pop_back());
    m_ptr = 2'd3;
    rst_n = 1'b1;
    hits  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) hits++;
    end
    n_cmp++; if (hits != 0) begin n_bad++; $display("[TB] FAIL mid_no_result: got %0d active cycles want 0", hits); end
    data_in = {16'h0103, 16'h0000, 16'h0000, 16'h00FF};
    submit(4'b1001);
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("[TB] FAIL mid_prio0: got %b want 0001", g); end
    submit(4'b1000);
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL mid_result0: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b1000) begin n_bad++; $display("[TB] FAIL mid_gnt3: got %b want 1000", g); end
    req = 4'b0000;
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL mid_result3: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    @(negedge clk);
  endtask

  task automatic test_priority_skip();
    logic [3:0] g;
    int         waited;
    exp_t       e;
    data_in = {16'h0F01, 16'h0000, 16'h0001, 16'h3000};
    submit(4'b0010);
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("[TB] FAIL skip_setup_gnt: got %b want 0010", g); end
    req = 4'b0000;
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL skip_setup_result: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    submit(4'b1001);
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b1000) begin n_bad++; $display("[TB] FAIL skip_first: got %b want 1000", g); end
    submit(4'b1001);
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL skip_result3: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    wait_gnt(g, waited);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("[TB] FAIL skip_second: got %b want 0001", g); end
    req = 4'b0000;
    wait_valid(waited);
    e = pop_exp();
    n_cmp++; if ({res_valid, res_id, res_parity} !== {1'b1, e.id, e.par}) begin n_bad++; $display("[TB] FAIL skip_result0: got v=%b id=%0d par=%b want v=1 id=%0d par=%b", res_valid, res_id, res_parity, e.id, e.par); end
    @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
  endtask

  initial begin
    $display("[TB] parity_scheduler bench start");
    test_reset();
    test_single_job();
    test_parity_values();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_op();
    test_priority_skip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parity_scheduler.md
# parity_scheduler

Time-shares one 4-input XOR parity stage among four requesters, with round-robin arbitration. A granted W-bit word is fed through the stage one nibble per cycle, and the running parity is accumulated. The result is presented on a valid/ready output port. The block sits between parity clients and the single shared XOR cascade, so the cascade needs no per-client copy.

## Interface
- W, 16, data word width per requester; must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- req  input  4  per-requester request; bit i belongs to requester i.
- data  input  4*W  requester i's word on data[i*W +: W].
- gnt  output  4  one-hot, one-cycle acceptance pulse.
- busy  output  1  high while a job is in RUN or DONE.
- res_valid  output  1  parity result available.
- res_ready  input  1  consumer accepts the result.
- res_id  output  2  index of the requester that owns the result.
- res_parity  output  1  XOR of all W bits of the granted word (even number of ones → 0).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - If req is nonzero at a clock edge, the block picks a winner by round-robin.
  - The search starts at index ptr+1 mod 4 and takes the first set req bit.
  - At that same edge the block:
    - captures data of the winner into shift register sr[W-1:0];
    - sets acc=0 and cnt=0;
    - sets ptr=winner and res_id=winner;
    - sets gnt[winner]=1 for exactly one cycle;
    - moves to RUN.
  - If req is zero, the block stays in IDLE.
- **RUN**, each edge:
  - acc ← acc ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[3], computed by the shared 4-input XOR cascade (a⊕b, then ⊕c, then ⊕d).
  - sr ← sr >> 4 and cnt ← cnt+1.
  - On the edge that processes nibble W/4−1: res_parity ← final acc, res_valid ← 1, move to DONE.
- **DONE**
  - res_valid, res_id and res_parity are held stable until res_ready=1 at an edge.
  - At that edge: res_valid ← 0 and the FSM moves to IDLE.
  - No arbitration happens in that same edge.
- req is ignored in RUN and DONE. No new grant is issued until the result has been consumed.
- Requester protocol:
  - Hold req and data stable until gnt is seen.
  - Deassert req, or present a new word, on the edge that ends the gnt cycle.
  - A req still high after that edge is treated as a new request.
- ptr update:
  - ptr changes only at a grant.
  - Reset value is 3, so requester 0 has first priority after reset.
- Widths:
  - cnt is wide enough for W/4 and wraps to 0 at each grant.
  - res_id is 2 bits and never exceeds 3.

## Timing
- Reset values: gnt=0, busy=0, res_valid=0, res_id=0, res_parity=0. Internally ptr=3, state IDLE, acc=0.
- Reset mid-operation: rst_n=0 at any edge forces all reset values.
  - Any in-flight job or pending result is discarded.
  - No gnt is issued on that edge.
- Job timeline (capture edge E0):
  - gnt high between E0 and E1; busy high from E0.
  - Nibbles are processed at edges E1..E_{W/4}.
  - res_valid rises after E_{W/4}.
- Result hand-off and throughput:
  - With res_ready held high, the transfer happens at E_{W/4+1} and the FSM is back in IDLE.
  - The earliest next capture is E_{W/4+2}.
  - Minimum job period is W/4+2 cycles, which is 6 for W=16.
- busy falls after the transfer edge.
- res_ready low stalls indefinitely in DONE; outputs are unchanged.
- Simultaneous requests resolve purely by round-robin from ptr+1.
- A request arriving on the transfer edge waits until the next edge.

## Test plan
- **Reset / single job:** rst_n low 2 cycles, then req=0001 with data[15:0]=16'h0001 and res_ready=1.
  - gnt=0001 for one cycle.
  - res_valid rises 4 cycles after the capture edge, with res_id=0 and res_parity=1.
  - busy drops one cycle later.
- **Parity values:** requester 2 submits 16'hFFFF → res_parity=0; 16'h8001 → 0; 16'h7000 → 1. Each result has res_id=2.
- **Round-robin:** req=1111 held, re-asserted after each gnt, res_ready=1.
  - Grant order is 0, 1, 2, 3, 0.
  - Consecutive captures are 6 cycles apart.
- **Back-pressure:** res_ready=0 for 10 cycles after res_valid, with req=0100 pending.
  - res_valid, res_id and res_parity stay stable.
  - No gnt is issued.
  - Raising res_ready transfers the result; gnt=0100 follows one edge later.
- **Reset mid-operation:** rst_n=0 for one edge during the 2nd RUN cycle.
  - All outputs return to their reset values and no result appears.
  - A following req=1000 is granted; requester 0 still has priority if it requests at the same time.
- **Priority after skip:** ptr=1, req=1001.
  - Requester 3 is granted first, then requester 0.
